// File: rtl/somador_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused over WIDTH cycles, valid/ready on both sides.
// Optional subtraction mode (port sub) enabled by defining SOMADOR_SERIAL_SUB_EN.
module somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SOMADOR_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             cell_sum;
    logic             cell_carry;
    logic             load;
    logic             last;

    // single full-adder slice, carry closed through carry_q
    assign cell_sum   = a_sh[0] ^ b_sh[0] ^ carry_q;
    assign cell_carry = (a_sh[0] & b_sh[0]) | (carry_q & (a_sh[0] ^ b_sh[0]));

    // sum bit enters at MSB; written as a wide shift so WIDTH=1 needs no special case
    assign acc_next = WIDTH'({cell_sum, acc} >> 1);
    assign last     = (cnt == CW'(WIDTH - 1));

`ifdef SOMADOR_SERIAL_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : carry_in;
`else
    assign b_load = b;
    assign c_load = carry_in;
`endif

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                a_sh    <= a;
                b_sh    <= b_load;
                carry_q <= c_load;
                cnt     <= '0;
            end else if (state == SHIFT) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                carry_q <= cell_carry;
                cnt     <= cnt + CW'(1);
                acc     <= acc_next;
                // visible result only changes on the DONE entry edge
                if (last) begin
                    sum       <= acc_next;
                    carry_out <= cell_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// Directed self-checking bench for somador_serial (WIDTH=8); sub tests only when SOMADOR_SERIAL_SUB_EN is defined.
module tb_somador_serial;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         carry_in  = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;
`ifdef SOMADOR_SERIAL_SUB_EN
    logic         sub_drv   = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    somador_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef SOMADOR_SERIAL_SUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // present operands at a falling edge; returns just after the accepting edge
    task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("start_ready", in_ready, 1);
        a        = ta;
        b        = tb_v;
        carry_in = tc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat0, input logic [W-1:0] es, input logic ec);
        int lat = lat0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, W);
        check({tag, "_sum"}, sum, es);
        check({tag, "_co"}, carry_out, ec);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consume_ov", out_valid, 0);
    endtask

    initial begin
        #12;
        check("rst_sum", sum, 0);
        check("rst_co", carry_out, 0);
        check("rst_ov", out_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", in_ready, 1);

        start(8'h5A, 8'h3C, 1'b0);
        check("shift_busy", busy, 1);
        check("shift_ready", in_ready, 0);
        check("shift_sum_held", sum, 0);
        wait_done("add1", 0, 8'h96, 1'b0);
        consume();
        check("idle_sum_kept", sum, 8'h96);

        // out_ready high while not in DONE must not disturb anything
        out_ready = 1'b1;
        start(8'hFF, 8'h01, 1'b0);
        wait_done("ovf", 0, 8'h00, 1'b1);
        consume();

        start(8'h00, 8'h00, 1'b1);
        wait_done("cin", 0, 8'h01, 1'b0);
        consume();

        start(8'h12, 8'h34, 1'b0);
        wait_done("bp", 0, 8'h46, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp_ov", out_valid, 1);
            check("bp_sum", sum, 8'h46);
            check("bp_co", carry_out, 0);
        end
        a         = 8'h80;
        b         = 8'h80;
        carry_in  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b_ready", in_ready, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_ov", out_valid, 0);
        check("b2b_busy", busy, 1);
        wait_done("b2b", 0, 8'h00, 1'b1);
        consume();

        start(8'h03, 8'h04, 1'b1);
        @(negedge clk);
        a        = 8'h11;
        b        = 8'h11;
        in_valid = 1'b1;
        check("ign_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("ign", 2, 8'h08, 1'b0);
        consume();

        start(8'h0F, 8'h0F, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_sum", sum, 0);
        check("arst_co", carry_out, 0);
        check("arst_ov", out_valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("arst_no_partial", out_valid, 0);
        start(8'h01, 8'h01, 1'b0);
        wait_done("post_rst", 0, 8'h02, 1'b0);
        consume();

`ifdef SOMADOR_SERIAL_SUB_EN
        sub_drv = 1'b1;
        start(8'h10, 8'h01, 1'b0);
        wait_done("sub1", 0, 8'h0F, 1'b1);
        consume();
        start(8'h01, 8'h02, 1'b1);
        wait_done("sub2", 0, 8'hFF, 1'b0);
        consume();
        sub_drv = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
